// File: rtl/regfile_hilo.sv
// Commits the writeback bus into the 32x32 GPR file, HI/LO and a GPR commit counter; reads are combinational, writes land in 1 edge.
// No backpressure: every cycle's bus is consumed. Defining REGFILE_BYPASS_EN adds same-cycle write-through on all read ports.
module regfile_hilo #(
   parameter int W_RF_WID = 104
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [W_RF_WID-1:0] W_RF_bus,
   input  logic [4:0]          raddr1,
   output logic [31:0]         rdata1,
   input  logic [4:0]          raddr2,
   output logic [31:0]         rdata2,
   output logic [31:0]         hi_rdata,
   output logic [31:0]         lo_rdata,
   output logic [31:0]         commit_cnt
);

   typedef struct packed {
      logic        hi_we;
      logic        lo_we;
      logic [31:0] hi_wdata;
      logic [31:0] lo_wdata;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
   } wb_bus_t;

   wb_bus_t          wb;
   logic [31:0][31:0] gpr;
   logic [31:0]      hi_q;
   logic [31:0]      lo_q;
   logic [31:0]      cnt_q;
   logic             gpr_wr;
   logic [31:0]      rd1;
   logic [31:0]      rd2;
   logic [31:0]      hi_rd;
   logic [31:0]      lo_rd;

   assign wb     = W_RF_bus;
   assign gpr_wr = wb.rf_we && (wb.rf_waddr != 5'd0);

   // Entry 0 is only ever cleared, so it stays a hard zero.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         gpr   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (gpr_wr) begin
            gpr[wb.rf_waddr] <= wb.rf_wdata;
            cnt_q            <= cnt_q + 32'd1;
         end
         if (wb.hi_we) hi_q <= wb.hi_wdata;
         if (wb.lo_we) lo_q <= wb.lo_wdata;
      end
   end

   always_comb begin
      rd1   = (raddr1 == 5'd0) ? 32'd0 : gpr[raddr1];
      rd2   = (raddr2 == 5'd0) ? 32'd0 : gpr[raddr2];
      hi_rd = hi_q;
      lo_rd = lo_q;
`ifdef REGFILE_BYPASS_EN
      if (gpr_wr && (raddr1 == wb.rf_waddr)) rd1 = wb.rf_wdata;
      if (gpr_wr && (raddr2 == wb.rf_waddr)) rd2 = wb.rf_wdata;
      if (wb.hi_we) hi_rd = wb.hi_wdata;
      if (wb.lo_we) lo_rd = wb.lo_wdata;
`endif
   end

   // Gate on reset so a live bus cannot leak through the bypass path.
   assign rdata1     = resetn ? rd1   : 32'd0;
   assign rdata2     = resetn ? rd2   : 32'd0;
   assign hi_rdata   = resetn ? hi_rd : 32'd0;
   assign lo_rdata   = resetn ? lo_rd : 32'd0;
   assign commit_cnt = resetn ? cnt_q : 32'd0;

endmodule

// File: tb/tb_regfile_hilo.sv
// Scoreboard bench for regfile_hilo; expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_hilo;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic         clk;
   logic         resetn;
   logic [103:0] W_RF_bus;
   logic [4:0]   raddr1;
   logic [4:0]   raddr2;
   logic [31:0]  rdata1;
   logic [31:0]  rdata2;
   logic [31:0]  hi_rdata;
   logic [31:0]  lo_rdata;
   logic [31:0]  commit_cnt;

   regfile_hilo #(.W_RF_WID(104)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .W_RF_bus   (W_RF_bus),
      .raddr1     (raddr1),
      .rdata1     (rdata1),
      .raddr2     (raddr2),
      .rdata2     (rdata2),
      .hi_rdata   (hi_rdata),
      .lo_rdata   (lo_rdata),
      .commit_cnt (commit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] m_gpr [32];
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   logic [31:0] m_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         0:       return rdata1;
         1:       return rdata2;
         2:       return hi_rdata;
         3:       return lo_rdata;
         default: return commit_cnt;
      endcase
   endfunction

   function automatic logic [31:0] m_rd(input logic [4:0] a, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
      if (!resetn || a == 5'd0) return 32'd0;
      if (BYP && we && wa == a) return wd;
      return m_gpr[a];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
      m_hi  = 32'd0;
      m_lo  = 32'd0;
      m_cnt = 32'd0;
   endtask

   // Called just after a falling edge: drive, score this cycle's reads, then retire the edge.
   task automatic step(input logic hwe, input logic lwe, input logic [31:0] hwd,
                       input logic [31:0] lwd, input logic rwe, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2,
                       input string tag);
      logic eff;
      exp_t e;
      W_RF_bus = {hwe, lwe, hwd, lwd, rwe, wa, wd};
      raddr1   = ra1;
      raddr2   = ra2;
      eff      = rwe && (wa != 5'd0);
      sb.push_back('{{tag, "_rd1"}, 0, m_rd(ra1, eff, wa, wd)});
      sb.push_back('{{tag, "_rd2"}, 1, m_rd(ra2, eff, wa, wd)});
      sb.push_back('{{tag, "_hi"}, 2, !resetn ? 32'd0 : (BYP && hwe) ? hwd : m_hi});
      sb.push_back('{{tag, "_lo"}, 3, !resetn ? 32'd0 : (BYP && lwe) ? lwd : m_lo});
      sb.push_back('{{tag, "_cnt"}, 4, resetn ? m_cnt : 32'd0});
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, observe(e.sel), e.val);
      end
      @(posedge clk);
      if (resetn) begin
         if (eff) begin
            m_gpr[wa] = wd;
            m_cnt     = m_cnt + 32'd1;
         end
         if (hwe) m_hi = hwd;
         if (lwe) m_lo = lwd;
      end
      @(negedge clk);
   endtask

   initial begin
      logic [4:0]  wa;
      logic [31:0] wd;
      resetn   = 1'b0;
      W_RF_bus = '0;
      raddr1   = 5'd0;
      raddr2   = 5'd0;
      model_clear();
      @(negedge clk);
      step(0, 0, 0, 0, 0, 5'd0, 0, 5'd1, 5'd2, "rst_idle");
      step(1, 1, 32'h1, 32'h2, 1, 5'd4, 32'h44, 5'd4, 5'd4, "rst_bus_ignored");
      resetn = 1'b1;

      step(0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, "wr_r5");
      step(0, 0, 0, 0, 0, 5'd0, 0, 5'd5, 5'd5, "rd_r5");
      step(0, 0, 0, 0, 1, 5'd0, 32'h12345678, 5'd0, 5'd0, "wr_r0");
      step(0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 5'd5, "rd_r0");
      step(0, 0, 0, 0, 1, 5'd7, 32'h11, 5'd1, 5'd2, "wr_r7a");
      step(0, 0, 0, 0, 1, 5'd7, 32'h22, 5'd7, 5'd5, "byp_r7");
      step(0, 0, 0, 0, 0, 5'd0, 0, 5'd7, 5'd7, "rd_r7");
      step(1, 0, 32'hA, 32'hB, 1, 5'd3, 32'hC, 5'd3, 5'd7, "hilo_r3");
      step(0, 0, 0, 0, 0, 5'd0, 0, 5'd3, 5'd0, "rd_hilo");
      step(0, 1, 32'h5, 32'h55, 0, 5'd3, 32'h99, 5'd3, 5'd3, "lo_only");
      step(1, 1, 32'h1111, 32'h2222, 0, 5'd0, 0, 5'd0, 5'd0, "hilo_both");
      step(0, 0, 0, 0, 0, 5'd0, 0, 5'd3, 5'd5, "rd_hilo2");

      for (int i = 0; i < 40; i++) begin
         wa = 5'($urandom_range(0, 31));
         wd = $urandom;
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
              1'($urandom_range(0, 1)), wa, wd, wa, 5'($urandom_range(0, 31)), "rand");
      end

      // Asynchronous reset between edges with nonzero state present.
      #2;
      resetn = 1'b0;
      model_clear();
      #1;
      check("async_rst_rd1", rdata1, 32'd0);
      check("async_rst_cnt", commit_cnt, 32'd0);
      @(negedge clk);
      step(1, 0, 32'h7, 0, 1, 5'd9, 32'h99, 5'd9, 5'd5, "in_rst_wr");
      resetn = 1'b1;
      step(0, 0, 0, 0, 1, 5'd9, 32'h1234, 5'd9, 5'd3, "first_wr");
      step(0, 0, 0, 0, 0, 5'd0, 0, 5'd9, 5'd5, "rd_first");

      // Counter wrap via preload.
      force dut.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.cnt_q;
      m_cnt = 32'hFFFF_FFFF;
      step(0, 0, 0, 0, 1, 5'd1, 32'h77, 5'd1, 5'd0, "wrap_wr");
      step(0, 0, 0, 0, 0, 5'd0, 0, 5'd1, 5'd9, "wrap_rd");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
